// File: rtl/priority_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : priority_encoder
//  Brief    : Edge-captured 8-line priority encoder with handshaked output.
//             Rising edges on d0..d7 are latched into a pending set; the
//             highest pending line is presented as {a,b,c} with v=1 and held
//             until ack. ovf is a sticky flag for edges on already-pending
//             lines.
//  Revision : 1.0 - initial release
// ============================================================================
module priority_encoder (
    input  logic clk,
    input  logic rst_n,
    input  logic e,
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    input  logic d4,
    input  logic d5,
    input  logic d6,
    input  logic d7,
    input  logic ack,
    output logic a,
    output logic b,
    output logic c,
    output logic v,
    output logic ovf
);

    localparam logic [0:0] C_IDLE    = 1'b0;
    localparam logic [0:0] C_PRESENT = 1'b1;

    logic [7:0] w_d;
    logic [7:0] r_prev;
    logic [7:0] r_pend;
    logic [7:0] w_pend_next;
    logic [7:0] w_rise;
    logic [7:0] w_set;
    logic [7:0] w_clr;
    logic       w_take;
    logic       w_any;
    logic       w_ovf_hit;
    logic [2:0] w_top_idx;
    logic [0:0] r_state;
    logic [0:0] w_state_next;
    logic [2:0] r_code;
    logic [2:0] w_code_next;
    logic       r_ovf;

    assign w_d    = {d7, d6, d5, d4, d3, d2, d1, d0};
    assign w_rise = w_d & ~r_prev;
    assign w_set  = {8{e}} & w_rise;

    // Acknowledge only counts while a code is actually on display.
    assign w_take = (r_state == C_PRESENT) & ack;
    assign w_clr  = w_take ? (8'b0000_0001 << r_code) : 8'b0000_0000;

    // A fresh edge beats a same-cycle clear so the new request is not lost.
    for (genvar gi = 0; gi < 8; gi++) begin : g_pend
        assign w_pend_next[gi] = w_set[gi] | (r_pend[gi] & ~w_clr[gi]);
    end

    // Overflow only when the line stays pending and is not being retired now.
    assign w_ovf_hit = |(w_set & r_pend & ~w_clr);
    assign w_any     = |r_pend;

    // Highest set bit of the pending vector (ascending scan, last hit wins).
    always_comb begin
        w_top_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (r_pend[i]) begin
                w_top_idx = 3'(i);
            end
        end
    end

    // Edge-detect history and pending set; updated every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 8'd0;
            r_pend <= 8'd0;
            r_ovf  <= 1'b0;
        end else begin
            r_prev <= w_d;
            r_pend <= w_pend_next;
            if (w_ovf_hit) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: present when anything is pending, retire on ack.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_IDLE:    if (w_any) w_state_next = C_PRESENT;
            C_PRESENT: if (ack)   w_state_next = C_IDLE;
            default:   w_state_next = C_IDLE;
        endcase
    end

    // FSM output decode: the code is loaded only on the IDLE->PRESENT step.
    always_comb begin
        w_code_next = r_code;
        if ((r_state == C_IDLE) && w_any) begin
            w_code_next = w_top_idx;
        end
    end

    // Presented code register; keeps its value while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code <= 3'd0;
        end else begin
            r_code <= w_code_next;
        end
    end

    assign a   = r_code[2];
    assign b   = r_code[1];
    assign c   = r_code[0];
    assign v   = r_state[0];
    assign ovf = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_priority_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_priority_encoder
//  Brief    : Scoreboard bench for priority_encoder with a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_priority_encoder;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       e     = 1'b0;
    logic       ack   = 1'b0;
    logic [7:0] d     = 8'd0;
    logic       a, b, c, v, ovf;

    int total = 0;
    int bad   = 0;

    priority_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .e     (e),
        .d0    (d[0]),
        .d1    (d[1]),
        .d2    (d[2]),
        .d3    (d[3]),
        .d4    (d[4]),
        .d5    (d[5]),
        .d6    (d[6]),
        .d7    (d[7]),
        .ack   (ack),
        .a     (a),
        .b     (b),
        .c     (c),
        .v     (v),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a set of pending lines, a "showing" flag and the
    // line on show. Presentation picks the largest pending line number.
    // ------------------------------------------------------------------
    bit m_pend [8];
    bit m_last [8];
    bit m_rise [8];
    bit m_show = 1'b0;
    int m_code = 0;
    bit m_ovf  = 1'b0;
    bit m_take;
    int m_best;
    int exp_q [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                m_pend[i] = 1'b0;
                m_last[i] = 1'b0;
            end
            m_show = 1'b0;
            m_code = 0;
            m_ovf  = 1'b0;
            exp_q.delete();
        end else begin
            m_take = m_show && (ack === 1'b1);
            m_best = -1;
            for (int i = 7; i >= 0; i--) begin
                if (m_pend[i] && m_best < 0) m_best = i;
            end
            for (int i = 0; i < 8; i++) begin
                m_rise[i] = (d[i] === 1'b1) && !m_last[i];
                if (e && m_rise[i] && m_pend[i] && !(m_take && m_code == i)) m_ovf = 1'b1;
            end
            if (m_take) m_pend[m_code] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (e && m_rise[i]) m_pend[i] = 1'b1;
                m_last[i] = d[i];
            end
            if (m_take) begin
                m_show = 1'b0;
            end else if (!m_show && m_best >= 0) begin
                m_show = 1'b1;
                m_code = m_best;
                exp_q.push_back(m_best);
            end
        end
    end

    // Monitor: pop one expected code per new presentation, and track the
    // model's view of v, code and ovf every cycle.
    bit v_seen = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            v_seen = 1'b0;
        end else begin
            if (v === 1'b1 && !v_seen) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_code: got %0d expected none (queue empty)", {a, b, c});
                end else begin
                    check("sb_code", {5'd0, a, b, c}, 8'(exp_q.pop_front()));
                end
            end
            check("v", {7'd0, v}, {7'd0, m_show});
            if (m_show) check("code", {5'd0, a, b, c}, 8'(m_code));
            check("ovf", {7'd0, ovf}, {7'd0, m_ovf});
            v_seen = (v === 1'b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_v(input string name);
        int n = 0;
        while (v !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        total++;
        if (v !== 1'b1) begin
            bad++;
            $display("FAIL %s: got v=%0b expected 1 within 30 cycles", name, v);
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic pulse(input int line);
        d[line] = 1'b1;
        tick();
        d[line] = 1'b0;
    endtask

    task automatic check_out(input string name, input logic ev, input logic [2:0] ecode);
        check({name, "_v"}, {7'd0, v}, {7'd0, ev});
        if (ev) check({name, "_code"}, {5'd0, a, b, c}, {5'd0, ecode});
    endtask

    initial begin
        // Reset state, forced without any clock edge.
        #1;
        check("rst_v", {7'd0, v}, 8'd0);
        check("rst_abc", {5'd0, a, b, c}, 8'd0);
        check("rst_ovf", {7'd0, ovf}, 8'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        e     = 1'b1;
        tick();

        // Single pulse on d5: two edges to presentation, then held.
        pulse(5);
        check("d5_lat1", {7'd0, v}, 8'd0);
        tick();
        check_out("d5_lat2", 1'b1, 3'd5);
        repeat (5) tick();
        check_out("d5_hold", 1'b1, 3'd5);
        do_ack();
        check("d5_ackv", {7'd0, v}, 8'd0);
        tick();

        // d2 and d6 together: 6 first, gap cycle, then 2.
        d[2] = 1'b1;
        d[6] = 1'b1;
        tick();
        d = 8'd0;
        tick();
        check_out("d26_first", 1'b1, 3'd6);
        do_ack();
        check("d26_gap", {7'd0, v}, 8'd0);
        tick();
        check_out("d26_second", 1'b1, 3'd2);
        do_ack();
        tick();
        check("d26_empty", {7'd0, v}, 8'd0);

        // Enable low: edge ignored; enabling later with the line held high is no edge.
        e    = 1'b0;
        d[3] = 1'b1;
        repeat (10) tick();
        check("e0_v", {7'd0, v}, 8'd0);
        check("e0_ovf", {7'd0, ovf}, 8'd0);
        e = 1'b1;
        repeat (5) tick();
        check("e1_held_v", {7'd0, v}, 8'd0);
        d[3] = 1'b0;
        tick();

        // No preemption: d7 waits behind code 1.
        pulse(1);
        tick();
        check_out("np_first", 1'b1, 3'd1);
        pulse(7);
        repeat (3) tick();
        check_out("np_hold", 1'b1, 3'd1);
        do_ack();
        tick();
        check_out("np_second", 1'b1, 3'd7);
        do_ack();
        tick();

        // Edge on the shown line coinciding with its ack: set wins, no ovf.
        pulse(0);
        tick();
        check_out("coin_first", 1'b1, 3'd0);
        d[0] = 1'b1;
        ack  = 1'b1;
        tick();
        d[0] = 1'b0;
        ack  = 1'b0;
        check("coin_gap", {7'd0, v}, 8'd0);
        tick();
        check_out("coin_again", 1'b1, 3'd0);
        check("coin_ovf", {7'd0, ovf}, 8'd0);
        do_ack();
        tick();

        // Repeat edge on pending line 4: sticky ovf.
        pulse(4);
        tick();
        check_out("ovf_first", 1'b1, 3'd4);
        pulse(4);
        check("ovf_set", {7'd0, ovf}, 8'd1);
        do_ack();
        repeat (3) tick();
        check("ovf_sticky", {7'd0, ovf}, 8'd1);
        check("ovf_idle_v", {7'd0, v}, 8'd0);
        rst_n = 1'b0;
        #1;
        check("ovf_rst", {7'd0, ovf}, 8'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            d   = 8'($urandom & $urandom & $urandom);
            e   = ($urandom_range(0, 3) != 0);
            ack = ($urandom_range(0, 2) == 0);
            tick();
        end
        d   = 8'd0;
        e   = 1'b1;
        ack = 1'b1;
        repeat (40) tick();
        ack = 1'b0;
        tick();
        check("rand_drained", {7'd0, v}, 8'd0);

        // Asynchronous reset mid-presentation with ovf set, d1 held through release.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        pulse(4);
        wait_v("mid_wait");
        pulse(4);
        check("mid_ovf_pre", {7'd0, ovf}, 8'd1);
        d[1]  = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_v", {7'd0, v}, 8'd0);
        check("mid_rst_abc", {5'd0, a, b, c}, 8'd0);
        check("mid_rst_ovf", {7'd0, ovf}, 8'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rel_edge1", {7'd0, v}, 8'd0);
        tick();
        check_out("rel_edge2", 1'b1, 3'd1);
        d[1] = 1'b0;
        do_ack();
        tick();
        check("q_empty", 8'(exp_q.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/priority_encoder.md
PRIORITY_ENCODER -- requirements
Module: priority_encoder

Interface
REQ-001 Parameters SHALL be: none; all widths are fixed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 e  input  1  enable; 1 = new request edges may be captured.
REQ-005 d0..d7  input  1 each  request lines; d7 is highest priority, d0 lowest.
REQ-006 ack  input  1  consumer acknowledge of the presented code.
REQ-007 a  output  1  code bit 2 (MSB) of presented request index.
REQ-008 b  output  1  code bit 1 of presented request index.
REQ-009 c  output  1  code bit 0 (LSB) of presented request index.
REQ-010 v  output  1  1 = {a,b,c} holds a valid pending request index.
REQ-011 ovf  output  1  sticky flag; a request edge arrived on an already-pending line.

Function
REQ-012 The block SHALL register d0..d7 each cycle into prev[7:0] for rising-edge detection.
REQ-013 A rise on line i SHALL be detected at edge k when di=1 at edge k and prev[i]=0.
REQ-014 With e=1 at edge k, a detected rise on line i SHALL set pend[i] at edge k.
REQ-015 With e=0, rises SHALL be ignored: no pend update, no ovf; existing pend bits and presentation are retained.
REQ-016 The FSM SHALL have two states: IDLE (v=0) and PRESENT (v=1).
REQ-017 IDLE: if pend!=0 at edge k, the highest pending index SHALL be latched into {a,b,c}, with v=1 and state PRESENT after edge k.
REQ-018 IDLE with pend==0 SHALL hold v=0 and leave {a,b,c} unchanged.
REQ-019 Latency: a rise sampled at edge k SHALL give v=1 after edge k+1 when the FSM is IDLE and no higher line is pending.
REQ-020 PRESENT: {a,b,c} and v SHALL stay stable until ack=1 is sampled.
REQ-021 Higher-priority arrivals during PRESENT SHALL NOT preempt; they SHALL wait in pend.
REQ-022 PRESENT with ack=1 at edge m SHALL clear pend[{a,b,c}], drive v=0, and enter IDLE after edge m.
REQ-023 The next presentation SHALL come no earlier than after edge m+1, so v is low for at least one cycle between codes.
REQ-024 If a new rise on the presented line coincides with its ack clear at edge m (e=1), the set SHALL win: pend bit stays 1 and ovf is unchanged.
REQ-025 A rise with e=1 on line i while pend[i]=1 (and not being cleared) SHALL set ovf; pend[i] stays 1, with no double count.
REQ-026 ack SHALL be ignored in IDLE.
REQ-027 Multiple simultaneous rises SHALL all set their pend bits in the same cycle.
REQ-028 All outputs SHALL be driven directly from registers.

Reset
REQ-029 rst_n=0 SHALL immediately force a=b=c=0, v=0, ovf=0, pend=0, prev=0, and state IDLE, regardless of clk.
REQ-030 Reset asserted mid-presentation SHALL discard all pending and presented requests.
REQ-031 ovf SHALL be cleared only by reset.
REQ-032 A line held high through reset release SHALL be detected as a rise at the first clock edge after release, provided e=1.

Verification
REQ-033 Reset, e=1, pulse d5 for 1 cycle -> v=1 with {a,b,c}=101 two edges later; hold ack=0 for 5 cycles -> {a,b,c} and v stable.
REQ-034 e=1, raise d2 and d6 in the same cycle -> code 110 is presented first; ack -> v=0 for 1 cycle, then code 010; ack -> v=0 and pend=0.
REQ-035 e=0, pulse d3 -> v stays 0 for 10 cycles and ovf=0; then e=1 with d3 still high -> no event, because no new rise occurs.
REQ-036 Present code 001, pulse d7 during PRESENT -> code 001 held until ack; then 111 is presented.
REQ-037 With pend[4]=1, pulse d4 again -> ovf=1; ack code 100 -> ovf remains 1 until rst_n=0.
REQ-038 rst_n=0 asynchronously mid-presentation -> v, a, b, c, ovf go 0 before the next clk edge; after release with d1 held high and e=1 -> code 001 is presented two edges later.
